pipelined_control_unit: RTL and testbench

- Second-generation ID-stage control for the 5-stage MIPS pipeline.
- Decodes opcode/funct into the control bundle and detects load-use hazards, stalling for a parametrised load latency.
- Inserts bubbles on stall or flush.
- Carries control through the ID/EX, EX/MEM and MEM/WB registers so downstream stages read stage-aligned signals.

---
 rtl/pipelined_control_unit.sv | 259 +++++++++++++++++++++++++
 tb/tb_pipelined_control_unit.sv | 461 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_control_unit.sv
// ---------------------------------------------------------------------------
// pipelined_control_unit
//
// ID-stage control for a 5-stage MIPS pipeline. Decodes Opcode/FuncCode into
// the control bundle, detects load-use hazards against the instruction that
// currently sits in EX and holds the front end for LOAD_USE_CYCLES cycles per
// hazard. Bubbles are inserted at the ID/EX boundary only; the control bundle
// is then carried through ID/EX, EX/MEM and MEM/WB so every stage reads
// stage-aligned signals.
//
// Parameters
//   ALUOP_W          ALUOp output width (>=4); codes live in the low 4 bits.
//   REG_W            register address width.
//   LOAD_USE_CYCLES  stall cycles per load-use hazard (1..7).
//
// Ports
//   CLK, Resetb                 clock (rising edge), synchronous active-low reset
//   Opcode, FuncCode            ID instruction fields [31:26] and [5:0]
//   Rs, Rt, Rd                  ID register fields
//   IDValid                     IF/ID holds a real instruction
//   Flush                       kill the ID instruction (taken branch/jump)
//   Stall                       combinational; hold PC and IF/ID
//   EX_*                        ID/EX register outputs (full control bundle)
//   MEM_*                       EX/MEM register outputs (memory + writeback)
//   WB_*                        MEM/WB register outputs (writeback)
//   IllegalOp                   one-cycle pulse when an undefined opcode enters EX
// ---------------------------------------------------------------------------
module pipelined_control_unit #(
  parameter int ALUOP_W         = 4,
  parameter int REG_W           = 5,
  parameter int LOAD_USE_CYCLES = 1
) (
  input  logic               CLK,
  input  logic               Resetb,
  input  logic [5:0]         Opcode,
  input  logic [5:0]         FuncCode,
  input  logic [REG_W-1:0]   Rs,
  input  logic [REG_W-1:0]   Rt,
  input  logic [REG_W-1:0]   Rd,
  input  logic               IDValid,
  input  logic               Flush,
  output logic               Stall,
  output logic               EX_RegDst,
  output logic               EX_ALUSrc,
  output logic               EX_Branch,
  output logic               EX_Jump,
  output logic               EX_SignExtend,
  output logic               EX_UseShamt,
  output logic [ALUOP_W-1:0] EX_ALUOp,
  output logic               EX_MemRead,
  output logic               EX_MemWrite,
  output logic               EX_MemToReg,
  output logic               EX_RegWrite,
  output logic [REG_W-1:0]   EX_DestReg,
  output logic               MEM_MemRead,
  output logic               MEM_MemWrite,
  output logic               MEM_MemToReg,
  output logic               MEM_RegWrite,
  output logic [REG_W-1:0]   MEM_DestReg,
  output logic               WB_MemToReg,
  output logic               WB_RegWrite,
  output logic [REG_W-1:0]   WB_DestReg,
  output logic               IllegalOp
);

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic       sign_ext;
    logic       use_shamt;
    logic [3:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
  } ctrl_t;

  // Counter reload leaves one stall cycle already accounted for by the
  // hazard cycle itself.
  localparam logic [2:0] STALL_RELOAD = 3'(LOAD_USE_CYCLES - 1);

  // Decode results
  ctrl_t            dec_ctrl;
  logic             dec_illegal;
  logic             dec_uses_rt;
  logic [REG_W-1:0] dec_dest;

  // ID/EX
  ctrl_t            ex_ctrl_q, ex_ctrl_d;
  logic [REG_W-1:0] ex_dest_q, ex_dest_d;
  logic             illegal_q, illegal_d;
  logic [2:0]       cnt_q, cnt_d;

  // EX/MEM
  logic             mem_mem_read_q, mem_mem_write_q, mem_mem_to_reg_q, mem_reg_write_q;
  logic [REG_W-1:0] mem_dest_q;

  // MEM/WB
  logic             wb_mem_to_reg_q, wb_reg_write_q;
  logic [REG_W-1:0] wb_dest_q;

  logic             hazard;

  // -------------------------------------------------------------------------
  // Decode
  // -------------------------------------------------------------------------
  always_comb begin
    dec_ctrl    = '0;
    dec_illegal = 1'b0;
    dec_uses_rt = 1'b0;
    case (Opcode)
      6'b000000: begin // R-type
        dec_ctrl.reg_dst   = 1'b1;
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_op    = 4'hF;
        // SLL / SRL / SRA take their shift amount from the shamt field
        dec_ctrl.use_shamt = (FuncCode == 6'b000000) || (FuncCode == 6'b000010) ||
                             (FuncCode == 6'b000011);
        dec_uses_rt        = 1'b1;
      end
      6'b100011: begin // LW
        dec_ctrl.alu_src    = 1'b1;
        dec_ctrl.mem_to_reg = 1'b1;
        dec_ctrl.reg_write  = 1'b1;
        dec_ctrl.mem_read   = 1'b1;
        dec_ctrl.sign_ext   = 1'b1;
        dec_ctrl.alu_op     = 4'h2;
      end
      6'b101011: begin // SW
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.mem_write = 1'b1;
        dec_ctrl.sign_ext  = 1'b1;
        dec_ctrl.alu_op    = 4'h2;
        dec_uses_rt        = 1'b1;
      end
      6'b000100: begin // BEQ
        dec_ctrl.branch   = 1'b1;
        dec_ctrl.sign_ext = 1'b1;
        dec_ctrl.alu_op   = 4'h6;
        dec_uses_rt       = 1'b1;
      end
      6'b000010: begin // J
        dec_ctrl.jump   = 1'b1;
        dec_ctrl.alu_op = 4'hF;
      end
      // Logical immediates: zero-extended
      6'b001101, 6'b001100, 6'b001110, 6'b001111: begin
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.reg_write = 1'b1;
        case (Opcode[1:0])
          2'b01:   dec_ctrl.alu_op = 4'h1; // ORI
          2'b00:   dec_ctrl.alu_op = 4'h0; // ANDI
          2'b10:   dec_ctrl.alu_op = 4'hA; // XORI
          default: dec_ctrl.alu_op = 4'hE; // LUI
        endcase
      end
      // Arithmetic / compare immediates: sign-extended
      6'b001000, 6'b001001, 6'b001010, 6'b001011: begin
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.sign_ext  = 1'b1;
        case (Opcode[1:0])
          2'b00:   dec_ctrl.alu_op = 4'h2; // ADDI
          2'b01:   dec_ctrl.alu_op = 4'h8; // ADDIU
          2'b10:   dec_ctrl.alu_op = 4'h7; // SLTI
          default: dec_ctrl.alu_op = 4'hB; // SLTIU
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  assign dec_dest = dec_illegal ? '0 : (dec_ctrl.reg_dst ? Rd : Rt);

  // -------------------------------------------------------------------------
  // Load-use hazard and stall
  // -------------------------------------------------------------------------
  assign hazard = IDValid && ex_ctrl_q.mem_read && (ex_dest_q != '0) &&
                  ((ex_dest_q == Rs) || (dec_uses_rt && (ex_dest_q == Rt)));

  assign Stall = !Flush && (hazard || (cnt_q != 3'd0));

  always_comb begin
    cnt_d     = cnt_q;
    ex_ctrl_d = '0;
    ex_dest_d = '0;
    illegal_d = 1'b0;
    if (Flush)
      cnt_d = 3'd0;
    else if (cnt_q != 3'd0)
      cnt_d = cnt_q - 3'd1;
    else if (hazard)
      cnt_d = STALL_RELOAD;
    // Flush, stall and empty slots all turn into the all-zero bubble
    if (!Flush && !Stall && IDValid) begin
      ex_ctrl_d = dec_ctrl;
      ex_dest_d = dec_dest;
      illegal_d = dec_illegal;
    end
  end

  // -------------------------------------------------------------------------
  // Pipeline registers
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!Resetb) begin
      cnt_q            <= 3'd0;
      ex_ctrl_q        <= '0;
      ex_dest_q        <= '0;
      illegal_q        <= 1'b0;
      mem_mem_read_q   <= 1'b0;
      mem_mem_write_q  <= 1'b0;
      mem_mem_to_reg_q <= 1'b0;
      mem_reg_write_q  <= 1'b0;
      mem_dest_q       <= '0;
      wb_mem_to_reg_q  <= 1'b0;
      wb_reg_write_q   <= 1'b0;
      wb_dest_q        <= '0;
    end else begin
      cnt_q            <= cnt_d;
      ex_ctrl_q        <= ex_ctrl_d;
      ex_dest_q        <= ex_dest_d;
      illegal_q        <= illegal_d;
      mem_mem_read_q   <= ex_ctrl_q.mem_read;
      mem_mem_write_q  <= ex_ctrl_q.mem_write;
      mem_mem_to_reg_q <= ex_ctrl_q.mem_to_reg;
      mem_reg_write_q  <= ex_ctrl_q.reg_write;
      mem_dest_q       <= ex_dest_q;
      wb_mem_to_reg_q  <= mem_mem_to_reg_q;
      wb_reg_write_q   <= mem_reg_write_q;
      wb_dest_q        <= mem_dest_q;
    end
  end

  assign EX_RegDst     = ex_ctrl_q.reg_dst;
  assign EX_ALUSrc     = ex_ctrl_q.alu_src;
  assign EX_Branch     = ex_ctrl_q.branch;
  assign EX_Jump       = ex_ctrl_q.jump;
  assign EX_SignExtend = ex_ctrl_q.sign_ext;
  assign EX_UseShamt   = ex_ctrl_q.use_shamt;
  assign EX_ALUOp      = ALUOP_W'(ex_ctrl_q.alu_op);
  assign EX_MemRead    = ex_ctrl_q.mem_read;
  assign EX_MemWrite   = ex_ctrl_q.mem_write;
  assign EX_MemToReg   = ex_ctrl_q.mem_to_reg;
  assign EX_RegWrite   = ex_ctrl_q.reg_write;
  assign EX_DestReg    = ex_dest_q;
  assign MEM_MemRead   = mem_mem_read_q;
  assign MEM_MemWrite  = mem_mem_write_q;
  assign MEM_MemToReg  = mem_mem_to_reg_q;
  assign MEM_RegWrite  = mem_reg_write_q;
  assign MEM_DestReg   = mem_dest_q;
  assign WB_MemToReg   = wb_mem_to_reg_q;
  assign WB_RegWrite   = wb_reg_write_q;
  assign WB_DestReg    = wb_dest_q;
  assign IllegalOp     = illegal_q;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// ---------------------------------------------------------------------------
// tb_pipelined_control_unit
//
// Two instances share one stimulus stream: index 0 has LOAD_USE_CYCLES=1,
// index 1 has LOAD_USE_CYCLES=3. A behavioural model tracks the expected
// stage contents as records and the stall window as an absolute cycle number.
// ---------------------------------------------------------------------------
module tb_pipelined_control_unit;

  typedef struct packed {
    logic       regdst, alusrc, branch, jump, sext, shamt;
    logic [3:0] aluop;
    logic       mr, mw, m2r, rw;
    logic [4:0] dest;
  } exp_t;

  typedef struct packed {
    logic       mr, mw, m2r, rw;
    logic [4:0] dest;
  } mem_t;

  typedef struct packed {
    logic       m2r, rw;
    logic [4:0] dest;
  } wb_t;

  localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2B, OP_BEQ = 6'h04;
  localparam logic [5:0] OP_J = 6'h02, OP_ORI = 6'h0D, OP_ANDI = 6'h0C, OP_XORI = 6'h0E;
  localparam logic [5:0] OP_LUI = 6'h0F, OP_ADDI = 6'h08, OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B, OP_BAD = 6'h3F;
  localparam logic [5:0] FN_ADD = 6'h20, FN_SRA = 6'h03;

  logic [5:0] op_list [13];
  logic [3:0] aluop_tab [13];

  logic       CLK = 1'b0;
  logic       Resetb, IDValid, Flush;
  logic [5:0] Opcode, FuncCode;
  logic [4:0] Rs, Rt, Rd;

  logic       stall_w [2];
  logic       ex_regdst [2], ex_alusrc [2], ex_branch [2], ex_jump [2], ex_sext [2], ex_shamt [2];
  logic [3:0] ex_aluop [2];
  logic       ex_mr [2], ex_mw [2], ex_m2r [2], ex_rw [2];
  logic [4:0] ex_dest [2];
  logic       mem_mr [2], mem_mw [2], mem_m2r [2], mem_rw [2];
  logic [4:0] mem_dest [2];
  logic       wb_m2r [2], wb_rw [2];
  logic [4:0] wb_dest [2];
  logic       illegal_w [2];

  always #5 CLK = ~CLK;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      pipelined_control_unit #(
        .ALUOP_W(4), .REG_W(5), .LOAD_USE_CYCLES(gi == 0 ? 1 : 3)
      ) u_dut (
        .CLK(CLK), .Resetb(Resetb), .Opcode(Opcode), .FuncCode(FuncCode),
        .Rs(Rs), .Rt(Rt), .Rd(Rd), .IDValid(IDValid), .Flush(Flush),
        .Stall(stall_w[gi]),
        .EX_RegDst(ex_regdst[gi]), .EX_ALUSrc(ex_alusrc[gi]), .EX_Branch(ex_branch[gi]),
        .EX_Jump(ex_jump[gi]), .EX_SignExtend(ex_sext[gi]), .EX_UseShamt(ex_shamt[gi]),
        .EX_ALUOp(ex_aluop[gi]), .EX_MemRead(ex_mr[gi]), .EX_MemWrite(ex_mw[gi]),
        .EX_MemToReg(ex_m2r[gi]), .EX_RegWrite(ex_rw[gi]), .EX_DestReg(ex_dest[gi]),
        .MEM_MemRead(mem_mr[gi]), .MEM_MemWrite(mem_mw[gi]), .MEM_MemToReg(mem_m2r[gi]),
        .MEM_RegWrite(mem_rw[gi]), .MEM_DestReg(mem_dest[gi]),
        .WB_MemToReg(wb_m2r[gi]), .WB_RegWrite(wb_rw[gi]), .WB_DestReg(wb_dest[gi]),
        .IllegalOp(illegal_w[gi])
      );
    end
  endgenerate

  int n_checks = 0;
  int n_pass   = 0;

  // Model state
  int   cyc = 0;
  int   stall_end [2];
  exp_t exp_ex [2];
  mem_t exp_mem [2];
  wb_t  exp_wb [2];
  logic exp_ill [2];
  logic exp_stall [2];
  logic obs_stall [2];

  function automatic int nval(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // Control table, straight from the opcode list
  function automatic void ref_decode(input logic [5:0] opc, input logic [5:0] fn,
                                     input logic [4:0] rt, input logic [4:0] rd,
                                     output exp_t e, output logic ill, output logic urt);
    e = '0; ill = 1'b0; urt = 1'b0;
    case (opc)
      OP_R:     begin e.regdst = 1; e.rw = 1; e.aluop = 4'hF; urt = 1;
                      e.shamt = (fn == 6'd0 || fn == 6'd2 || fn == 6'd3); end
      OP_LW:    begin e.alusrc = 1; e.m2r = 1; e.rw = 1; e.mr = 1; e.sext = 1; e.aluop = 4'h2; end
      OP_SW:    begin e.alusrc = 1; e.mw = 1; e.sext = 1; e.aluop = 4'h2; urt = 1; end
      OP_BEQ:   begin e.branch = 1; e.sext = 1; e.aluop = 4'h6; urt = 1; end
      OP_J:     begin e.jump = 1; e.aluop = 4'hF; end
      OP_ORI:   begin e.alusrc = 1; e.rw = 1; e.aluop = 4'h1; end
      OP_ANDI:  begin e.alusrc = 1; e.rw = 1; e.aluop = 4'h0; end
      OP_XORI:  begin e.alusrc = 1; e.rw = 1; e.aluop = 4'hA; end
      OP_LUI:   begin e.alusrc = 1; e.rw = 1; e.aluop = 4'hE; end
      OP_ADDI:  begin e.alusrc = 1; e.rw = 1; e.sext = 1; e.aluop = 4'h2; end
      OP_ADDIU: begin e.alusrc = 1; e.rw = 1; e.sext = 1; e.aluop = 4'h8; end
      OP_SLTI:  begin e.alusrc = 1; e.rw = 1; e.sext = 1; e.aluop = 4'h7; end
      OP_SLTIU: begin e.alusrc = 1; e.rw = 1; e.sext = 1; e.aluop = 4'hB; end
      default:  ill = 1'b1;
    endcase
    if (!ill) e.dest = e.regdst ? rd : rt;
  endfunction

  function automatic exp_t obs_ex(input int k);
    exp_t o;
    o.regdst = ex_regdst[k]; o.alusrc = ex_alusrc[k]; o.branch = ex_branch[k];
    o.jump = ex_jump[k]; o.sext = ex_sext[k]; o.shamt = ex_shamt[k]; o.aluop = ex_aluop[k];
    o.mr = ex_mr[k]; o.mw = ex_mw[k]; o.m2r = ex_m2r[k]; o.rw = ex_rw[k]; o.dest = ex_dest[k];
    return o;
  endfunction

  function automatic mem_t obs_mem(input int k);
    return '{mem_mr[k], mem_mw[k], mem_m2r[k], mem_rw[k], mem_dest[k]};
  endfunction

  function automatic wb_t obs_wb(input int k);
    return '{wb_m2r[k], wb_rw[k], wb_dest[k]};
  endfunction

  // One ID cycle: drive, sample Stall, advance the model, clock edge.
  task automatic tick(input logic rstb, input logic v, input logic fl,
                      input logic [5:0] opc, input logic [5:0] fn,
                      input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    exp_t d;
    logic ill, urt, hz, st;
    Resetb = rstb; IDValid = v; Flush = fl; Opcode = opc; FuncCode = fn;
    Rs = rs; Rt = rt; Rd = rd;
    #1;
    ref_decode(opc, fn, rt, rd, d, ill, urt);
    for (int k = 0; k < 2; k++) begin
      hz = v && exp_ex[k].mr && (exp_ex[k].dest != 5'd0) &&
           ((exp_ex[k].dest == rs) || (urt && exp_ex[k].dest == rt));
      st = !fl && (hz || (cyc < stall_end[k]));
      exp_stall[k] = st;
      obs_stall[k] = stall_w[k];
      if (!rstb) begin
        stall_end[k] = cyc;
        exp_ex[k] = '0; exp_mem[k] = '0; exp_wb[k] = '0; exp_ill[k] = 1'b0;
      end else begin
        if (fl) stall_end[k] = cyc;
        else if (hz && cyc >= stall_end[k]) stall_end[k] = cyc + nval(k);
        exp_wb[k]  = '{exp_mem[k].m2r, exp_mem[k].rw, exp_mem[k].dest};
        exp_mem[k] = '{exp_ex[k].mr, exp_ex[k].mw, exp_ex[k].m2r, exp_ex[k].rw, exp_ex[k].dest};
        exp_ex[k]  = (fl || st || !v) ? '0 : d;
        exp_ill[k] = ill && v && !fl && !st;
      end
    end
    $display("cyc %0d rstb=%b v=%b fl=%b op=%b fn=%b rs=%0d rt=%0d rd=%0d stall n1=%b n3=%b",
             cyc, rstb, v, fl, opc, fn, rs, rt, rd, obs_stall[0], obs_stall[1]);
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic nop();
    tick(1'b1, 1'b0, 1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      stall_end[k] = 0; exp_ex[k] = '0; exp_mem[k] = '0; exp_wb[k] = '0; exp_ill[k] = 1'b0;
    end
    tick(1'b0, 1'b1, 1'b0, OP_LW, 6'h00, 5'd1, 5'd5, 5'd0);
    tick(1'b0, 1'b1, 1'b0, OP_LW, 6'h00, 5'd1, 5'd5, 5'd0);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (obs_stall[k] !== 1'b0) $display("FAIL reset_stall n%0d got %b want 0", nval(k), obs_stall[k]);
      else n_pass++;
      n_checks++;
      if (obs_ex(k) !== exp_t'(0)) $display("FAIL reset_ex n%0d got %h want 0", nval(k), obs_ex(k));
      else n_pass++;
      n_checks++;
      if (obs_mem(k) !== mem_t'(0) || obs_wb(k) !== wb_t'(0) || illegal_w[k] !== 1'b0)
        $display("FAIL reset_mem_wb_ill n%0d got %h %h %b want 0", nval(k), obs_mem(k), obs_wb(k), illegal_w[k]);
      else n_pass++;
    end
  endtask

  task automatic test_decode();
    for (int i = 0; i < 13; i++) begin
      tick(1'b1, 1'b1, 1'b0, op_list[i], FN_ADD, 5'd1, 5'd2, 5'd3);
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs_ex(k) !== exp_ex[k])
          $display("FAIL decode_bundle op=%b n%0d got %h want %h", op_list[i], nval(k), obs_ex(k), exp_ex[k]);
        else n_pass++;
      end
      n_checks++;
      if (ex_aluop[0] !== aluop_tab[i] || illegal_w[0] !== 1'b0)
        $display("FAIL decode_aluop op=%b got %h/%b want %h/0", op_list[i], ex_aluop[0], illegal_w[0], aluop_tab[i]);
      else n_pass++;
      if (op_list[i] == OP_ADDIU) begin
        n_checks++;
        if (ex_sext[0] !== 1'b1 || ex_alusrc[0] !== 1'b1)
          $display("FAIL decode_addiu got sext=%b alusrc=%b want 1/1", ex_sext[0], ex_alusrc[0]);
        else n_pass++;
      end
      nop();
    end
    tick(1'b1, 1'b1, 1'b0, OP_R, FN_SRA, 5'd1, 5'd2, 5'd3);
    n_checks++;
    if (ex_shamt[0] !== 1'b1 || ex_dest[0] !== 5'd3)
      $display("FAIL decode_sra got shamt=%b dest=%0d want 1/3", ex_shamt[0], ex_dest[0]);
    else n_pass++;
    tick(1'b1, 1'b1, 1'b0, OP_R, FN_ADD, 5'd1, 5'd2, 5'd3);
    n_checks++;
    if (ex_shamt[0] !== 1'b0) $display("FAIL decode_add_shamt got %b want 0", ex_shamt[0]);
    else n_pass++;
    nop();
  endtask

  task automatic test_load_use();
    int scount [2];
    int bubbles [2];
    int enter_at [2];
    for (int k = 0; k < 2; k++) begin scount[k] = 0; bubbles[k] = 0; enter_at[k] = -1; end
    nop();
    tick(1'b1, 1'b1, 1'b0, OP_LW, 6'h00, 5'd1, 5'd5, 5'd0);
    for (int t = 1; t <= 5; t++) begin
      tick(1'b1, 1'b1, 1'b0, OP_R, FN_ADD, 5'd5, 5'd2, 5'd6);
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs_stall[k] !== exp_stall[k])
          $display("FAIL loaduse_stall n%0d t%0d got %b want %b", nval(k), t, obs_stall[k], exp_stall[k]);
        else n_pass++;
        if (obs_stall[k] === 1'b1) begin
          scount[k]++;
          if (ex_rw[k] === 1'b0 && ex_mr[k] === 1'b0) bubbles[k]++;
        end
        if (enter_at[k] < 0 && ex_rw[k] === 1'b1 && ex_dest[k] === 5'd6) enter_at[k] = t;
      end
    end
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (scount[k] != nval(k) || bubbles[k] != nval(k))
        $display("FAIL loaduse_count n%0d got stall=%0d bubbles=%0d want %0d", nval(k), scount[k], bubbles[k], nval(k));
      else n_pass++;
      n_checks++;
      if (enter_at[k] != nval(k) + 1)
        $display("FAIL loaduse_enter n%0d got %0d want %0d", nval(k), enter_at[k], nval(k) + 1);
      else n_pass++;
    end
  endtask

  task automatic test_flush();
    // Flush in the hazard cycle itself
    nop();
    tick(1'b1, 1'b1, 1'b0, OP_LW, 6'h00, 5'd1, 5'd5, 5'd0);
    tick(1'b1, 1'b1, 1'b1, OP_R, FN_ADD, 5'd5, 5'd2, 5'd6);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (obs_stall[k] !== 1'b0 || ex_rw[k] !== 1'b0)
        $display("FAIL flush_hazard n%0d got stall=%b rw=%b want 0/0", nval(k), obs_stall[k], ex_rw[k]);
      else n_pass++;
    end
    // Flush on the second cycle of a 3-cycle stall
    nop();
    tick(1'b1, 1'b1, 1'b0, OP_LW, 6'h00, 5'd1, 5'd5, 5'd0);
    tick(1'b1, 1'b1, 1'b0, OP_R, FN_ADD, 5'd5, 5'd2, 5'd6);
    n_checks++;
    if (obs_stall[1] !== 1'b1) $display("FAIL flush_mid_first got %b want 1", obs_stall[1]);
    else n_pass++;
    tick(1'b1, 1'b1, 1'b1, OP_R, FN_ADD, 5'd5, 5'd2, 5'd6);
    n_checks++;
    if (obs_stall[1] !== 1'b0 || ex_rw[1] !== 1'b0)
      $display("FAIL flush_mid_drop got stall=%b rw=%b want 0/0", obs_stall[1], ex_rw[1]);
    else n_pass++;
    tick(1'b1, 1'b1, 1'b0, OP_R, FN_ADD, 5'd5, 5'd2, 5'd6);
    n_checks++;
    if (obs_stall[1] !== 1'b0 || ex_dest[1] !== 5'd6 || ex_rw[1] !== 1'b1)
      $display("FAIL flush_mid_after got stall=%b dest=%0d rw=%b want 0/6/1", obs_stall[1], ex_dest[1], ex_rw[1]);
    else n_pass++;
  endtask

  task automatic test_reset_mid_stall();
    nop();
    tick(1'b1, 1'b1, 1'b0, OP_LW, 6'h00, 5'd1, 5'd5, 5'd0);
    tick(1'b1, 1'b1, 1'b0, OP_R, FN_ADD, 5'd5, 5'd2, 5'd6);
    tick(1'b0, 1'b1, 1'b0, OP_R, FN_ADD, 5'd5, 5'd2, 5'd6);
    n_checks++;
    if (obs_stall[1] !== 1'b1 || obs_ex(1) !== exp_t'(0))
      $display("FAIL rst_mid_stall got stall=%b ex=%h want 1/0", obs_stall[1], obs_ex(1));
    else n_pass++;
    tick(1'b1, 1'b1, 1'b0, OP_R, FN_ADD, 5'd5, 5'd2, 5'd6);
    n_checks++;
    if (obs_stall[1] !== 1'b0 || ex_dest[1] !== 5'd6)
      $display("FAIL rst_mid_after got stall=%b dest=%0d want 0/6", obs_stall[1], ex_dest[1]);
    else n_pass++;
  endtask

  task automatic test_illegal();
    nop();
    tick(1'b1, 1'b1, 1'b0, OP_BAD, 6'h00, 5'd1, 5'd2, 5'd3);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (illegal_w[k] !== 1'b1 || obs_ex(k) !== exp_t'(0))
        $display("FAIL illegal_pulse n%0d got ill=%b ex=%h want 1/0", nval(k), illegal_w[k], obs_ex(k));
      else n_pass++;
    end
    nop();
    n_checks++;
    if (illegal_w[0] !== 1'b0) $display("FAIL illegal_width got %b want 0", illegal_w[0]);
    else n_pass++;
    tick(1'b1, 1'b1, 1'b1, OP_BAD, 6'h00, 5'd1, 5'd2, 5'd3);
    n_checks++;
    if (illegal_w[0] !== 1'b0) $display("FAIL illegal_flushed got %b want 0", illegal_w[0]);
    else n_pass++;
    // Load to $0 followed by a use of $0
    nop();
    tick(1'b1, 1'b1, 1'b0, OP_LW, 6'h00, 5'd1, 5'd0, 5'd0);
    tick(1'b1, 1'b1, 1'b0, OP_R, FN_ADD, 5'd0, 5'd0, 5'd4);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (obs_stall[k] !== 1'b0 || ex_dest[k] !== 5'd4)
        $display("FAIL zero_reg n%0d got stall=%b dest=%0d want 0/4", nval(k), obs_stall[k], ex_dest[k]);
      else n_pass++;
    end
  endtask

  task automatic test_pipeline_carry();
    nop();
    tick(1'b1, 1'b1, 1'b0, OP_LW, 6'h00, 5'd1, 5'd7, 5'd0);
    n_checks++;
    if (ex_mr[0] !== 1'b1 || ex_dest[0] !== 5'd7)
      $display("FAIL carry_ex got mr=%b dest=%0d want 1/7", ex_mr[0], ex_dest[0]);
    else n_pass++;
    nop();
    n_checks++;
    if (mem_mr[0] !== 1'b1 || mem_m2r[0] !== 1'b1 || mem_dest[0] !== 5'd7 || ex_mr[0] !== 1'b0)
      $display("FAIL carry_mem got mr=%b m2r=%b dest=%0d want 1/1/7", mem_mr[0], mem_m2r[0], mem_dest[0]);
    else n_pass++;
    nop();
    n_checks++;
    if (wb_m2r[0] !== 1'b1 || wb_rw[0] !== 1'b1 || wb_dest[0] !== 5'd7 || mem_mr[0] !== 1'b0)
      $display("FAIL carry_wb got m2r=%b rw=%b dest=%0d want 1/1/7", wb_m2r[0], wb_rw[0], wb_dest[0]);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int scount [2];
    int iter;
    scount[0] = 0; scount[1] = 0;
    nop();
    tick(1'b1, 1'b1, 1'b0, OP_LW, 6'h00, 5'd1, 5'd5, 5'd0);
    iter = 0;
    do begin
      tick(1'b1, 1'b1, 1'b0, OP_LW, 6'h00, 5'd5, 5'd6, 5'd0);
      for (int k = 0; k < 2; k++) if (obs_stall[k] === 1'b1) scount[k]++;
      iter++;
    end while (exp_stall[1] && iter < 10);
    iter = 0;
    do begin
      tick(1'b1, 1'b1, 1'b0, OP_R, FN_ADD, 5'd6, 5'd2, 5'd7);
      for (int k = 0; k < 2; k++) if (obs_stall[k] === 1'b1) scount[k]++;
      iter++;
    end while (exp_stall[1] && iter < 10);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (scount[k] != 2 * nval(k))
        $display("FAIL b2b_stalls n%0d got %0d want %0d", nval(k), scount[k], 2 * nval(k));
      else n_pass++;
    end
    n_checks++;
    if (ex_dest[1] !== 5'd7 || ex_rw[1] !== 1'b1)
      $display("FAIL b2b_enter got dest=%0d rw=%b want 7/1", ex_dest[1], ex_rw[1]);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [5:0] c_op, c_fn;
    logic [4:0] c_rs, c_rt, c_rd;
    logic       c_v, fl, rstb, hold;
    int         pick;
    hold = 1'b0;
    c_op = 6'h00; c_fn = 6'h00; c_rs = 5'd0; c_rt = 5'd0; c_rd = 5'd0; c_v = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!hold) begin
        pick = $urandom_range(15);
        c_op = (pick < 13) ? op_list[pick] : 6'($urandom_range(63));
        case ($urandom_range(4))
          0: c_fn = 6'h00;
          1: c_fn = 6'h02;
          2: c_fn = FN_SRA;
          3: c_fn = FN_ADD;
          default: c_fn = 6'($urandom_range(63));
        endcase
        c_rs = 5'($urandom_range(3));
        c_rt = 5'($urandom_range(3));
        c_rd = 5'($urandom_range(3));
        c_v  = ($urandom_range(7) != 0);
      end
      fl   = ($urandom_range(7) == 0);
      rstb = ($urandom_range(63) != 0);
      tick(rstb, c_v, fl, c_op, c_fn, c_rs, c_rt, c_rd);
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (obs_stall[k] !== exp_stall[k])
          $display("FAIL rnd_stall n%0d cyc%0d got %b want %b", nval(k), cyc, obs_stall[k], exp_stall[k]);
        else n_pass++;
        n_checks++;
        if (obs_ex(k) !== exp_ex[k])
          $display("FAIL rnd_ex n%0d cyc%0d got %h want %h", nval(k), cyc, obs_ex(k), exp_ex[k]);
        else n_pass++;
        n_checks++;
        if (obs_mem(k) !== exp_mem[k])
          $display("FAIL rnd_mem n%0d cyc%0d got %h want %h", nval(k), cyc, obs_mem(k), exp_mem[k]);
        else n_pass++;
        n_checks++;
        if (obs_wb(k) !== exp_wb[k])
          $display("FAIL rnd_wb n%0d cyc%0d got %h want %h", nval(k), cyc, obs_wb(k), exp_wb[k]);
        else n_pass++;
        n_checks++;
        if (illegal_w[k] !== exp_ill[k])
          $display("FAIL rnd_ill n%0d cyc%0d got %b want %b", nval(k), cyc, illegal_w[k], exp_ill[k]);
        else n_pass++;
      end
      // A real IF/ID keeps its instruction while the front end is held
      hold = exp_stall[1] && rstb;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    op_list   = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ORI, OP_ANDI, OP_XORI,
                  OP_LUI, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU};
    aluop_tab = '{4'hF, 4'h2, 4'h2, 4'h6, 4'hF, 4'h1, 4'h0, 4'hA,
                  4'hE, 4'h2, 4'h8, 4'h7, 4'hB};
    Resetb = 1'b0; IDValid = 1'b0; Flush = 1'b0; Opcode = '0; FuncCode = '0;
    Rs = '0; Rt = '0; Rd = '0;
    test_reset();
    test_decode();
    test_load_use();
    test_flush();
    test_reset_mid_stall();
    test_illegal();
    test_pipeline_carry();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
